// File: rtl/selftest_pkg.sv
// Shared definitions for the self-test sequencer: register offsets, STATUS bit positions, state and error encodings.
package selftest_pkg;

    localparam int unsigned REG_STATUS      = 0;
    localparam int unsigned REG_DIO_CFG     = 12;
    localparam int unsigned REG_DIO_STATUS  = 16;
    localparam int unsigned REG_BRAM_SEED   = 24;
    localparam int unsigned REG_BRAM_STATUS = 28;

    localparam int STATUS_BRAM_TVALID_BIT = 6;
    localparam int STATUS_DIO_TVALID_BIT  = 3;
    localparam int BRAM_PASS_BIT          = 0;

    typedef enum logic [1:0] {
        ERR_NONE = 2'd0,
        ERR_DATA = 2'd1,
        ERR_BUS  = 2'd2,
        ERR_POLL = 2'd3
    } err_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_SEED,
        ST_WR_DIO,
        ST_POLL,
        ST_RD_BRAM,
        ST_RD_DIO,
        ST_FIN
    } state_t;

    typedef enum logic [2:0] {
        MS_IDLE,
        MS_WADDR,
        MS_WRESP,
        MS_RADDR,
        MS_RRESP
    } mst_state_t;

endpackage

// File: rtl/selftest_sequencer_if.sv
// AXI4-Lite master-side bus bundle used by the self-test sequencer.
interface selftest_sequencer_if #(
    parameter int ADDR_W = 8
);
    logic [ADDR_W-1:0] m_awaddr;
    logic              m_awvalid;
    logic              m_awready;
    logic [31:0]       m_wdata;
    logic              m_wvalid;
    logic              m_wready;
    logic [1:0]        m_bresp;
    logic              m_bvalid;
    logic              m_bready;
    logic [ADDR_W-1:0] m_araddr;
    logic              m_arvalid;
    logic              m_arready;
    logic [31:0]       m_rdata;
    logic              m_rvalid;
    logic              m_rready;
    logic [1:0]        m_rresp;

    modport master (
        output m_awaddr, m_awvalid, m_wdata, m_wvalid, m_bready,
        output m_araddr, m_arvalid, m_rready,
        input  m_awready, m_wready, m_bresp, m_bvalid,
        input  m_arready, m_rdata, m_rvalid, m_rresp
    );

    modport slave (
        input  m_awaddr, m_awvalid, m_wdata, m_wvalid, m_bready,
        input  m_araddr, m_arvalid, m_rready,
        output m_awready, m_wready, m_bresp, m_bvalid,
        output m_arready, m_rdata, m_rvalid, m_rresp
    );

endinterface

// File: rtl/selftest_sequencer_axil_single_master.sv
// Purpose: executes a single AXI4-Lite read or write per command, one transaction outstanding.
// Latency: valids rise the cycle after the command; response pulse in the cycle bvalid/rvalid is taken.
// Backpressure: valids and payload held until each channel's ready; new command only accepted when idle.
module axil_single_master
    import selftest_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_cmd_vld,
    input  logic              i_cmd_write,
    input  logic [ADDR_W-1:0] i_cmd_addr,
    input  logic [31:0]       i_cmd_wdata,
    output logic              o_cmd_rdy,
    output logic              o_rsp_vld,
    output logic [31:0]       o_rsp_rdata,
    output logic [1:0]        o_rsp_resp,
    selftest_sequencer_if.master m_axi
);

    mst_state_t        r_state;
    mst_state_t        w_state_nxt;
    logic              r_aw_done;
    logic              r_w_done;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic              w_aw_hs;
    logic              w_w_hs;

    // Valids/readies decode straight from registered state, so they are glitch-free and drop in reset.
    assign m_axi.m_awvalid = (r_state == MS_WADDR) && !r_aw_done;
    assign m_axi.m_wvalid  = (r_state == MS_WADDR) && !r_w_done;
    assign m_axi.m_bready  = (r_state == MS_WRESP);
    assign m_axi.m_arvalid = (r_state == MS_RADDR);
    assign m_axi.m_rready  = (r_state == MS_RRESP);
    assign m_axi.m_awaddr  = r_addr;
    assign m_axi.m_araddr  = r_addr;
    assign m_axi.m_wdata   = r_wdata;

    assign w_aw_hs     = m_axi.m_awvalid && m_axi.m_awready;
    assign w_w_hs      = m_axi.m_wvalid && m_axi.m_wready;
    assign o_cmd_rdy   = (r_state == MS_IDLE);
    assign o_rsp_rdata = m_axi.m_rdata;

    always_comb begin
        w_state_nxt = r_state;
        o_rsp_vld   = 1'b0;
        o_rsp_resp  = 2'b00;
        case (r_state)
            MS_IDLE: begin
                if (i_cmd_vld)
                    w_state_nxt = i_cmd_write ? MS_WADDR : MS_RADDR;
            end
            MS_WADDR: begin
                if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs))
                    w_state_nxt = MS_WRESP;
            end
            MS_WRESP: begin
                if (m_axi.m_bvalid) begin
                    w_state_nxt = MS_IDLE;
                    o_rsp_vld   = 1'b1;
                    o_rsp_resp  = m_axi.m_bresp;
                end
            end
            MS_RADDR: begin
                if (m_axi.m_arready)
                    w_state_nxt = MS_RRESP;
            end
            MS_RRESP: begin
                if (m_axi.m_rvalid) begin
                    w_state_nxt = MS_IDLE;
                    o_rsp_vld   = 1'b1;
                    o_rsp_resp  = m_axi.m_rresp;
                end
            end
            default: w_state_nxt = MS_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= MS_IDLE;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == MS_IDLE && i_cmd_vld) begin
                r_addr    <= i_cmd_addr;
                r_wdata   <= i_cmd_wdata;
                r_aw_done <= 1'b0;
                r_w_done  <= 1'b0;
            end else if (r_state == MS_WADDR) begin
                if (w_aw_hs) r_aw_done <= 1'b1;
                if (w_w_hs)  r_w_done  <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/selftest_sequencer.sv
// Purpose: autonomous AXI-Lite master running one BRAM+DIO self-test (seed, configure, poll, collect, grade); SEQ_AUTORERUN_EN repeats passing runs.
// Latency: busy the cycle after an accepted start; done pulses one cycle after the last response is taken.
// Backpressure: one bus transaction outstanding, stalls on any ready; start ignored unless idle.
module selftest_sequencer
    import selftest_pkg::*;
#(
    parameter int          POLL_LIMIT  = 1024,
    parameter int          ADDR_W      = 8,
    parameter logic [31:0] DIO_ERR_MSK = 32'hFFFF_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_start,
    input  logic [31:0] i_seed,
    input  logic [31:0] i_dio_cfg,
    output logic        o_busy,
    output logic        o_done,
    output logic [1:0]  o_err,
    output logic [31:0] o_dio_result,
    selftest_sequencer_if.master m_axi
);

    localparam int CNT_W = $clog2(POLL_LIMIT + 1);

    state_t             r_state;
    state_t             w_state_nxt;
    err_t               r_err;
    err_t               w_err_nxt;
    logic [31:0]        r_seed;
    logic [31:0]        r_dio_cfg;
    logic [31:0]        r_dio_result;
    logic [CNT_W-1:0]   r_poll_cnt;
    logic               r_bram_ok;

    logic               w_cmd_vld;
    logic               w_cmd_write;
    logic [ADDR_W-1:0]  w_cmd_addr;
    logic [31:0]        w_cmd_wdata;
    logic               w_cmd_rdy;
    logic               w_rsp_vld;
    logic [31:0]        w_rsp_rdata;
    logic [1:0]         w_rsp_resp;
    logic               w_bus_err;
    logic               w_poll_ok;
    logic               w_poll_last;

    axil_single_master #(.ADDR_W(ADDR_W)) u_mst (
        .clk         (clk),
        .reset       (reset),
        .i_cmd_vld   (w_cmd_vld),
        .i_cmd_write (w_cmd_write),
        .i_cmd_addr  (w_cmd_addr),
        .i_cmd_wdata (w_cmd_wdata),
        .o_cmd_rdy   (w_cmd_rdy),
        .o_rsp_vld   (w_rsp_vld),
        .o_rsp_rdata (w_rsp_rdata),
        .o_rsp_resp  (w_rsp_resp),
        .m_axi       (m_axi)
    );

    assign w_bus_err   = w_rsp_vld && (w_rsp_resp != 2'b00);
    assign w_poll_ok   = w_rsp_rdata[STATUS_BRAM_TVALID_BIT] && w_rsp_rdata[STATUS_DIO_TVALID_BIT];
    assign w_poll_last = (32'(r_poll_cnt) + 32'd1) >= 32'(POLL_LIMIT);

    assign o_busy       = (r_state != ST_IDLE) && (r_state != ST_FIN);
    assign o_done       = (r_state == ST_FIN);
    assign o_err        = r_err;
    assign o_dio_result = r_dio_result;

    always_comb begin
        w_state_nxt = r_state;
        w_err_nxt   = r_err;
        w_cmd_vld   = 1'b0;
        w_cmd_write = 1'b0;
        w_cmd_addr  = '0;
        w_cmd_wdata = '0;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_state_nxt = ST_WR_SEED;
                    w_err_nxt   = ERR_NONE;
                end
            end
            ST_WR_SEED: begin
                w_cmd_vld   = w_cmd_rdy;
                w_cmd_write = 1'b1;
                w_cmd_addr  = ADDR_W'(REG_BRAM_SEED);
                w_cmd_wdata = r_seed;
                if (w_rsp_vld) w_state_nxt = ST_WR_DIO;
            end
            ST_WR_DIO: begin
                w_cmd_vld   = w_cmd_rdy;
                w_cmd_write = 1'b1;
                w_cmd_addr  = ADDR_W'(REG_DIO_CFG);
                w_cmd_wdata = r_dio_cfg;
                if (w_rsp_vld) w_state_nxt = ST_POLL;
            end
            ST_POLL: begin
                w_cmd_vld  = w_cmd_rdy;
                w_cmd_addr = ADDR_W'(REG_STATUS);
                if (w_rsp_vld) begin
                    if (w_poll_ok) begin
                        w_state_nxt = ST_RD_BRAM;
                    end else if (w_poll_last) begin
                        w_state_nxt = ST_FIN;
                        w_err_nxt   = ERR_POLL;
                    end
                end
            end
            ST_RD_BRAM: begin
                w_cmd_vld  = w_cmd_rdy;
                w_cmd_addr = ADDR_W'(REG_BRAM_STATUS);
                if (w_rsp_vld) w_state_nxt = ST_RD_DIO;
            end
            ST_RD_DIO: begin
                w_cmd_vld  = w_cmd_rdy;
                w_cmd_addr = ADDR_W'(REG_DIO_STATUS);
                if (w_rsp_vld) begin
                    w_state_nxt = ST_FIN;
                    w_err_nxt   = (!r_bram_ok || ((w_rsp_rdata & DIO_ERR_MSK) != 32'h0)) ? ERR_DATA : ERR_NONE;
                end
            end
            ST_FIN: begin
`ifdef SEQ_AUTORERUN_EN
                // A start held high during FIN is the stop request.
                if (r_err == ERR_NONE && !i_start)
                    w_state_nxt = ST_WR_SEED;
                else
                    w_state_nxt = ST_IDLE;
`else
                w_state_nxt = ST_IDLE;
`endif
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        // A bad response overrides whatever the state wanted; the response itself is already consumed.
        if (w_bus_err) begin
            w_state_nxt = ST_FIN;
            w_err_nxt   = ERR_BUS;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_err        <= ERR_NONE;
            r_seed       <= '0;
            r_dio_cfg    <= '0;
            r_dio_result <= '0;
            r_poll_cnt   <= '0;
            r_bram_ok    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_err   <= w_err_nxt;
            if (r_state == ST_IDLE && i_start) begin
                r_seed    <= i_seed;
                r_dio_cfg <= i_dio_cfg;
            end
`ifdef SEQ_AUTORERUN_EN
            if (r_state == ST_FIN && w_state_nxt == ST_WR_SEED)
                r_seed <= r_seed + 32'd1;
`endif
            if (r_state != ST_POLL)
                r_poll_cnt <= '0;
            else if (w_rsp_vld)
                r_poll_cnt <= r_poll_cnt + CNT_W'(1);
            if (r_state == ST_RD_BRAM && w_rsp_vld)
                r_bram_ok <= w_rsp_rdata[BRAM_PASS_BIT];
            if (r_state == ST_RD_DIO && w_rsp_vld)
                r_dio_result <= w_rsp_rdata;
        end
    end

endmodule
